// File: rtl/button_hit_judge.sv
// Synchronises, debounces and edge-detects four mole buttons, then judges each press
// once per round against the latched mole pattern, emitting one-cycle hit/miss pulses.
module button_hit_judge #(
   parameter int DEBOUNCE_CYCLES = 200000,
   parameter int CNT_W           = 18
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] button,
   input  logic [3:0] mole_in,
   input  logic       round_tick,
   input  logic       game_en,
   output logic [3:0] btn_level,
   output logic [3:0] hit,
   output logic [3:0] miss,
   output logic [3:0] mole_q
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [3:0]       sync1_q, sync1_d;
   logic [3:0]       sync2_q, sync2_d;
   logic [3:0]       level_q, level_d;
   logic [CNT_W-1:0] cnt_q [4];
   logic [CNT_W-1:0] cnt_d [4];
   logic [3:0]       press_q, press_d;
   logic [3:0]       lock_q, lock_d;
   logic [3:0]       hit_q, hit_d;
   logic [3:0]       miss_q, miss_d;
   logic [3:0]       round_mole_q, round_mole_d;

   logic [3:0]       lock_eff;
   logic [3:0]       mole_eff;
   logic [3:0]       judge;

   always_comb begin
      sync1_d = button;
      sync2_d = sync1_q;
      level_d = level_q;
      cnt_d   = cnt_q;
      for (int i = 0; i < 4; i++) begin
         if (sync2_q[i] == level_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CNT_MAX) begin
            level_d[i] = ~level_q[i];
            cnt_d[i]   = '0;
         end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
         end
      end
      // Pulse on the edge where the debounced level rises, so the judge sees it next cycle.
      press_d = level_d & ~level_q;
   end

   always_comb begin
      // A round_tick in the same cycle opens the new round before the press is judged.
      lock_eff     = round_tick ? 4'b0000 : lock_q;
      mole_eff     = round_tick ? mole_in : round_mole_q;
      round_mole_d = mole_eff;
      judge        = press_q & {4{game_en}} & ~lock_eff;
      hit_d        = judge & mole_eff;
      miss_d       = judge & ~mole_eff;
      lock_d       = lock_eff | judge;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q      <= '0;
         sync2_q      <= '0;
         level_q      <= '0;
         for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
         press_q      <= '0;
         lock_q       <= '0;
         hit_q        <= '0;
         miss_q       <= '0;
         round_mole_q <= '0;
      end else begin
         sync1_q      <= sync1_d;
         sync2_q      <= sync2_d;
         level_q      <= level_d;
         for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
         press_q      <= press_d;
         lock_q       <= lock_d;
         hit_q        <= hit_d;
         miss_q       <= miss_d;
         round_mole_q <= round_mole_d;
      end
   end

   assign btn_level = level_q;
   assign hit       = hit_q;
   assign miss      = miss_q;
   assign mole_q    = round_mole_q;

endmodule

// File: tb/tb_button_hit_judge.sv
// Table-driven bench for button_hit_judge with DEBOUNCE_CYCLES=4; each row holds its
// inputs for n cycles and expects constant outputs after every one of those edges.
module tb_button_hit_judge;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] button;
   logic [3:0] mole_in;
   logic       round_tick;
   logic       game_en;
   logic [3:0] btn_level;
   logic [3:0] hit;
   logic [3:0] miss;
   logic [3:0] mole_q;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [3:0] btn;
      logic [3:0] mole;
      logic       tick;
      logic       en;
      int         n;
      logic [3:0] lvl;
      logic [3:0] hit;
      logic [3:0] miss;
      logic [3:0] mq;
   } vec_t;

   vec_t vecs[$];

   button_hit_judge #(.DEBOUNCE_CYCLES(4), .CNT_W(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .button     (button),
      .mole_in    (mole_in),
      .round_tick (round_tick),
      .game_en    (game_en),
      .btn_level  (btn_level),
      .hit        (hit),
      .miss       (miss),
      .mole_q     (mole_q)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", nm, act, exp);
      end
   endtask

   task automatic chk_all(input string nm, input logic [3:0] lvl, input logic [3:0] h,
                          input logic [3:0] m, input logic [3:0] mq);
      chk({nm, " btn_level"}, btn_level, lvl);
      chk({nm, " hit"},       hit,       h);
      chk({nm, " miss"},      miss,      m);
      chk({nm, " mole_q"},    mole_q,    mq);
   endtask

   task automatic add(input logic [3:0] btn, input logic [3:0] mole, input logic tick,
                      input logic en, input int n, input logic [3:0] lvl,
                      input logic [3:0] h, input logic [3:0] m, input logic [3:0] mq);
      vec_t v;
      v.btn = btn; v.mole = mole; v.tick = tick; v.en = en; v.n = n;
      v.lvl = lvl; v.hit = h; v.miss = m; v.mq = mq;
      vecs.push_back(v);
   endtask

   initial begin
      // btn, mole, tick, en, n, lvl, hit, miss, mole_q
      // Round 1 (moles 0,2 up): clean press on button 0 -> hit after edge 7
      add(4'b0001, 4'b0101, 1, 1, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0101);
      add(4'b0001, 4'b0101, 0, 1, 4, 4'b0000, 4'b0000, 4'b0000, 4'b0101);
      add(4'b0001, 4'b0101, 0, 1, 1, 4'b0001, 4'b0000, 4'b0000, 4'b0101);
      add(4'b0001, 4'b0101, 0, 1, 1, 4'b0001, 4'b0001, 4'b0000, 4'b0101);
      add(4'b0001, 4'b0101, 0, 1, 1, 4'b0001, 4'b0000, 4'b0000, 4'b0101);
      // Button 1 press on a down mole -> miss; re-press in the same round dropped
      add(4'b0011, 4'b0101, 0, 1, 5, 4'b0001, 4'b0000, 4'b0000, 4'b0101);
      add(4'b0011, 4'b0101, 0, 1, 1, 4'b0011, 4'b0000, 4'b0000, 4'b0101);
      add(4'b0011, 4'b0101, 0, 1, 1, 4'b0011, 4'b0000, 4'b0010, 4'b0101);
      add(4'b0001, 4'b0101, 0, 1, 5, 4'b0011, 4'b0000, 4'b0000, 4'b0101);
      add(4'b0001, 4'b0101, 0, 1, 1, 4'b0001, 4'b0000, 4'b0000, 4'b0101);
      add(4'b0011, 4'b0101, 0, 1, 5, 4'b0001, 4'b0000, 4'b0000, 4'b0101);
      add(4'b0011, 4'b0101, 0, 1, 1, 4'b0011, 4'b0000, 4'b0000, 4'b0101);
      add(4'b0011, 4'b0101, 0, 1, 2, 4'b0011, 4'b0000, 4'b0000, 4'b0101);
      add(4'b0001, 4'b0101, 0, 1, 5, 4'b0011, 4'b0000, 4'b0000, 4'b0101);
      add(4'b0001, 4'b0101, 0, 1, 1, 4'b0001, 4'b0000, 4'b0000, 4'b0101);
      // Round 2 (mole 1 up): press button 1 -> hit
      add(4'b0011, 4'b0010, 1, 1, 1, 4'b0001, 4'b0000, 4'b0000, 4'b0010);
      add(4'b0011, 4'b0010, 0, 1, 4, 4'b0001, 4'b0000, 4'b0000, 4'b0010);
      add(4'b0011, 4'b0010, 0, 1, 1, 4'b0011, 4'b0000, 4'b0000, 4'b0010);
      add(4'b0011, 4'b0010, 0, 1, 1, 4'b0011, 4'b0010, 4'b0000, 4'b0010);
      add(4'b0011, 4'b0010, 0, 1, 1, 4'b0011, 4'b0000, 4'b0000, 4'b0010);
      // Button 2 bounces of 3 cycles are rejected, then a 4-cycle hold is accepted
      add(4'b0111, 4'b0010, 0, 1, 3, 4'b0011, 4'b0000, 4'b0000, 4'b0010);
      add(4'b0011, 4'b0010, 0, 1, 3, 4'b0011, 4'b0000, 4'b0000, 4'b0010);
      add(4'b0111, 4'b0010, 0, 1, 3, 4'b0011, 4'b0000, 4'b0000, 4'b0010);
      add(4'b0011, 4'b0010, 0, 1, 5, 4'b0011, 4'b0000, 4'b0000, 4'b0010);
      add(4'b0111, 4'b0010, 0, 1, 4, 4'b0011, 4'b0000, 4'b0000, 4'b0010);
      add(4'b0011, 4'b0010, 0, 1, 1, 4'b0011, 4'b0000, 4'b0000, 4'b0010);
      add(4'b0011, 4'b0010, 0, 1, 1, 4'b0111, 4'b0000, 4'b0000, 4'b0010);
      add(4'b0011, 4'b0010, 0, 1, 1, 4'b0111, 4'b0000, 4'b0100, 4'b0010);
      add(4'b0011, 4'b0010, 0, 1, 2, 4'b0111, 4'b0000, 4'b0000, 4'b0010);
      add(4'b0011, 4'b0010, 0, 1, 1, 4'b0011, 4'b0000, 4'b0000, 4'b0010);
      // Press on button 3 judged in the same cycle as a tick -> uses the new pattern
      add(4'b0011, 4'b0000, 1, 1, 1, 4'b0011, 4'b0000, 4'b0000, 4'b0000);
      add(4'b1011, 4'b1000, 0, 1, 5, 4'b0011, 4'b0000, 4'b0000, 4'b0000);
      add(4'b1011, 4'b1000, 0, 1, 1, 4'b1011, 4'b0000, 4'b0000, 4'b0000);
      add(4'b1011, 4'b1000, 1, 1, 1, 4'b1011, 4'b1000, 4'b0000, 4'b1000);
      add(4'b1011, 4'b1000, 0, 1, 1, 4'b1011, 4'b0000, 4'b0000, 4'b1000);
      // game_en low drops a press without locking; the next enabled press is judged
      add(4'b1010, 4'b1000, 0, 1, 5, 4'b1011, 4'b0000, 4'b0000, 4'b1000);
      add(4'b1010, 4'b1000, 0, 1, 1, 4'b1010, 4'b0000, 4'b0000, 4'b1000);
      add(4'b1011, 4'b1000, 0, 0, 5, 4'b1010, 4'b0000, 4'b0000, 4'b1000);
      add(4'b1011, 4'b1000, 0, 0, 1, 4'b1011, 4'b0000, 4'b0000, 4'b1000);
      add(4'b1011, 4'b1000, 0, 0, 2, 4'b1011, 4'b0000, 4'b0000, 4'b1000);
      add(4'b1010, 4'b1000, 0, 1, 5, 4'b1011, 4'b0000, 4'b0000, 4'b1000);
      add(4'b1010, 4'b1000, 0, 1, 1, 4'b1010, 4'b0000, 4'b0000, 4'b1000);
      add(4'b1011, 4'b1000, 0, 1, 5, 4'b1010, 4'b0000, 4'b0000, 4'b1000);
      add(4'b1011, 4'b1000, 0, 1, 1, 4'b1011, 4'b0000, 4'b0000, 4'b1000);
      add(4'b1011, 4'b1000, 0, 1, 1, 4'b1011, 4'b0000, 4'b0001, 4'b1000);
      add(4'b1011, 4'b1000, 0, 1, 1, 4'b1011, 4'b0000, 4'b0000, 4'b1000);

      reset      = 1'b1;
      button     = 4'b0000;
      mole_in    = 4'b0000;
      round_tick = 1'b0;
      game_en    = 1'b1;
      #12;
      chk_all("reset", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      @(negedge clk);
      reset = 1'b0;

      foreach (vecs[r]) begin
         for (int c = 0; c < vecs[r].n; c++) begin
            @(negedge clk);
            button     = vecs[r].btn;
            mole_in    = vecs[r].mole;
            round_tick = vecs[r].tick && (c == 0);
            game_en    = vecs[r].en;
            @(posedge clk);
            #1;
            chk_all($sformatf("row%0d.%0d", r, c), vecs[r].lvl, vecs[r].hit,
                    vecs[r].miss, vecs[r].mq);
         end
      end

      // Release button 1 and reset while its counter sits at 2, mid-round
      @(negedge clk);
      button     = 4'b1001;
      round_tick = 1'b0;
      game_en    = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk("pre-reset btn_level", btn_level, 4'b1011);
      #2;
      reset = 1'b1;
      #1;
      chk_all("async reset", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      repeat (2) @(posedge clk);
      #1;
      chk_all("held reset", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      @(negedge clk);
      reset = 1'b0;
      // Buttons 0 and 3 held: full re-debounce, then both judged as misses (mole_q cleared)
      for (int c = 1; c <= 5; c++) begin
         @(posedge clk);
         #1;
         chk_all($sformatf("post-reset e%0d", c), 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      end
      @(posedge clk);
      #1;
      chk_all("post-reset e6", 4'b1001, 4'b0000, 4'b0000, 4'b0000);
      @(posedge clk);
      #1;
      chk_all("post-reset e7", 4'b1001, 4'b0000, 4'b1001, 4'b0000);
      @(posedge clk);
      #1;
      chk_all("post-reset e8", 4'b1001, 4'b0000, 4'b0000, 4'b0000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
